cp0_exc_sched: RTL and testbench

Dual-lane exception and interrupt scheduler placed between the two memory-stage lanes and CP0. Each cycle it chooses at most one event: an interrupt, the oldest lane exception, or ERET. It commits that event to CP0 as a single one-cycle record, then flushes the pipeline and hands a redirect PC to fetch through a ready/valid handshake. Lane 1 is always older than lane 2.

---
 rtl/cp0_exc_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_cp0_exc_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_sched.sv
// cp0_exc_sched: picks at most one interrupt, lane exception or ERET per cycle
// and commits it to CP0 as a one-cycle record. It then flushes the pipeline and
// hands a redirect PC to fetch over a ready/valid handshake. Lane 1 is always
// the older instruction.
module cp0_exc_sched #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2              // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,          // asynchronous, active-low
    input  logic        valid_1,
    input  logic        valid_2,
    input  logic [7:0]  exc_1,
    input  logic [7:0]  exc_2,
    input  logic [31:0] pc_1,
    input  logic [31:0] pc_2,
    input  logic        ds_1,
    input  logic        branch_1,
    input  logic [31:0] vaddr_1,
    input  logic [31:0] vaddr_2,
    input  logic        int_pending,
    input  logic        status_exl,
    input  logic [31:0] epc_i,
    output logic        exc_commit,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic        badv_we,
    output logic [31:0] exc_badvaddr,
    output logic        eret_commit,
    output logic        kill_2,
    output logic        flush_o,
    output logic        busy_o,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    // Result of decoding one lane's exception flags.
    typedef struct packed {
        logic [4:0] code;
        logic       badv_pc;    // BadVAddr comes from the lane PC
        logic       badv_va;    // BadVAddr comes from the lane data address
    } flag_dec_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    // Flag priority inside one lane is 0,1,4,3,2,5,7. The ERET flag (bit 6) is
    // handled separately.
    function automatic flag_dec_t decode_flags(input logic [7:0] f);
        flag_dec_t d;
        d = '0;
        if (f[0]) begin
            d.code    = 5'd4;
            d.badv_pc = 1'b1;
        end else if (f[1]) begin
            d.code = 5'd10;
        end else if (f[4]) begin
            d.code = 5'd8;
        end else if (f[3]) begin
            d.code = 5'd9;
        end else if (f[2]) begin
            d.code = 5'd12;
        end else if (f[5]) begin
            d.code    = 5'd4;
            d.badv_va = 1'b1;
        end else if (f[7]) begin
            d.code    = 5'd5;
            d.badv_va = 1'b1;
        end
        return d;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_exc_commit;
    logic        r_eret_commit;
    logic [4:0]  r_code;
    logic [31:0] r_epc;
    logic        r_bd;
    logic        r_badv_we;
    logic [31:0] r_badvaddr;
    logic [31:0] r_redirect_pc;

    logic        w_int;
    logic        w_exc_1;
    logic        w_eret_1;
    logic        w_exc_2;
    logic        w_eret_2;
    flag_dec_t   w_dec_1;
    flag_dec_t   w_dec_2;

    logic        w_take;
    logic        w_is_eret;
    logic        w_from_l1;
    logic [4:0]  w_code;
    logic [31:0] w_epc;
    logic        w_bd;
    logic        w_badv_we;
    logic [31:0] w_badvaddr;

    // Qualify each candidate event. Lane faults are masked while EXL is set,
    // but ERET is still honoured.
    assign w_int    = int_pending && !status_exl && valid_1;
    assign w_exc_1  = valid_1 && ((|exc_1[5:0]) || exc_1[7]) && !status_exl;
    assign w_eret_1 = valid_1 && exc_1[6];
    assign w_exc_2  = valid_2 && ((|exc_2[5:0]) || exc_2[7]) && !status_exl;
    assign w_eret_2 = valid_2 && exc_2[6];
    assign w_dec_1  = decode_flags(exc_1);
    assign w_dec_2  = decode_flags(exc_2);

    // Pick the winning event. Selection only happens in IDLE.
    always_comb begin
        // NOTE: every signal gets a default first so that no path through the
        // if/else chain leaves it unassigned, which would infer a latch.
        w_take     = 1'b0;
        w_is_eret  = 1'b0;
        w_from_l1  = 1'b0;
        w_code     = 5'd0;
        w_epc      = 32'd0;
        w_bd       = 1'b0;
        w_badv_we  = 1'b0;
        w_badvaddr = 32'd0;
        if (r_state == S_IDLE) begin
            if (w_int || w_exc_1 || w_eret_1) begin
                w_take    = 1'b1;
                w_from_l1 = 1'b1;
                w_epc     = ds_1 ? (pc_1 - 32'd4) : pc_1;
                w_bd      = ds_1;
                if (w_int) begin
                    w_code = 5'd0;
                end else if (w_exc_1) begin
                    w_code     = w_dec_1.code;
                    w_badv_we  = w_dec_1.badv_pc || w_dec_1.badv_va;
                    w_badvaddr = w_dec_1.badv_pc ? pc_1 : vaddr_1;
                end else begin
                    w_is_eret = 1'b1;
                end
            end else if (w_exc_2 || w_eret_2) begin
                w_take = 1'b1;
                w_epc  = branch_1 ? pc_1 : pc_2;
                w_bd   = branch_1;
                if (w_exc_2) begin
                    w_code     = w_dec_2.code;
                    w_badv_we  = w_dec_2.badv_pc || w_dec_2.badv_va;
                    w_badvaddr = w_dec_2.badv_pc ? pc_2 : vaddr_2;
                end else begin
                    w_is_eret = 1'b1;
                end
            end
        end
    end

    // State register and flush counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> DRAIN for FLUSH_CYCLES cycles -> REDIR until accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = FLUSH_LOAD;
                end
            end
            S_DRAIN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_REDIR;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_REDIR: begin
                if (redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Commit pulses, the CP0 record and the redirect target, all latched when an event is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the record registers are reset because CP0 and fetch may
            // observe them straight after reset. They are flops, not a memory.
            r_exc_commit  <= 1'b0;
            r_eret_commit <= 1'b0;
            r_code        <= 5'd0;
            r_epc         <= 32'd0;
            r_bd          <= 1'b0;
            r_badv_we     <= 1'b0;
            r_badvaddr    <= 32'd0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_exc_commit  <= w_take && !w_is_eret;
            r_eret_commit <= w_take && w_is_eret;
            if (w_take && !w_is_eret) begin
                r_code     <= w_code;
                r_epc      <= w_epc;
                r_bd       <= w_bd;
                r_badv_we  <= w_badv_we;
                r_badvaddr <= w_badvaddr;
            end
            if (w_take) begin
                r_redirect_pc <= w_is_eret ? epc_i : EXC_VECTOR;
            end
        end
    end

    assign exc_commit     = r_exc_commit;
    assign eret_commit    = r_eret_commit;
    assign exc_code       = r_code;
    assign exc_epc        = r_epc;
    assign exc_bd         = r_bd;
    assign badv_we        = r_badv_we;
    assign exc_badvaddr   = r_badvaddr;
    assign redirect_pc    = r_redirect_pc;
    assign flush_o        = (r_state == S_DRAIN);
    assign busy_o         = (r_state != S_IDLE);
    assign redirect_valid = (r_state == S_REDIR);
    // Lane 2 is younger, so its write-back is squashed whenever lane 1 or an
    // interrupt wins. This signal is held low while reset is asserted.
    assign kill_2         = reset && w_take && w_from_l1;

endmodule

// File: tb/tb_cp0_exc_sched.sv
// Directed testbench for cp0_exc_sched. It uses the default parameters:
// EXC_VECTOR = 0xBFC0_0380 and FLUSH_CYCLES = 2.
module tb_cp0_exc_sched;

    logic        clk;
    logic        reset;
    logic        valid_1, valid_2;
    logic [7:0]  exc_1, exc_2;
    logic [31:0] pc_1, pc_2;
    logic        ds_1, branch_1;
    logic [31:0] vaddr_1, vaddr_2;
    logic        int_pending, status_exl;
    logic [31:0] epc_i;
    logic        exc_commit;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        badv_we;
    logic [31:0] exc_badvaddr;
    logic        eret_commit;
    logic        kill_2;
    logic        flush_o;
    logic        busy_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks   = 0;
    int failures = 0;
    int commits;

    cp0_exc_sched dut (
        .clk            (clk),
        .reset          (reset),
        .valid_1        (valid_1),
        .valid_2        (valid_2),
        .exc_1          (exc_1),
        .exc_2          (exc_2),
        .pc_1           (pc_1),
        .pc_2           (pc_2),
        .ds_1           (ds_1),
        .branch_1       (branch_1),
        .vaddr_1        (vaddr_1),
        .vaddr_2        (vaddr_2),
        .int_pending    (int_pending),
        .status_exl     (status_exl),
        .epc_i          (epc_i),
        .exc_commit     (exc_commit),
        .exc_code       (exc_code),
        .exc_epc        (exc_epc),
        .exc_bd         (exc_bd),
        .badv_we        (badv_we),
        .exc_badvaddr   (exc_badvaddr),
        .eret_commit    (eret_commit),
        .kill_2         (kill_2),
        .flush_o        (flush_o),
        .busy_o         (busy_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then settle for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_1     = 1'b0;
        valid_2     = 1'b0;
        exc_1       = 8'h00;
        exc_2       = 8'h00;
        pc_1        = 32'h0;
        pc_2        = 32'h0;
        ds_1        = 1'b0;
        branch_1    = 1'b0;
        vaddr_1     = 32'h0;
        vaddr_2     = 32'h0;
        int_pending = 1'b0;
        status_exl  = 1'b0;
        epc_i       = 32'h0;
    endtask

    // Bounded wait for the scheduler to return to IDLE.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && busy_o; i++) tick();
        check(tag, busy_o, 1'b0);
    endtask

    initial begin
        clear_inputs();
        redirect_ready = 1'b1;
        reset          = 1'b0;

        // ---- Reset state: kill_2 must stay low even while an interrupt is presented.
        valid_1     = 1'b1;
        int_pending = 1'b1;
        #2;
        check("rst_kill_2",      kill_2,         1'b0);
        check("rst_exc_commit",  exc_commit,     1'b0);
        check("rst_flush",       flush_o,        1'b0);
        check("rst_busy",        busy_o,         1'b0);
        check("rst_redir_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc,    32'h0);
        check("rst_exc_code",    exc_code,       5'd0);
        tick();
        clear_inputs();
        #2 reset = 1'b1;
        tick();

        // ---- Lane 1 overflow.
        valid_1 = 1'b1; exc_1 = 8'h04; pc_1 = 32'hBFC0_0100; ds_1 = 1'b0;
        #1;
        check("ovf_kill_2", kill_2, 1'b1);
        tick();
        clear_inputs();
        check("ovf_commit",  exc_commit,  1'b1);
        check("ovf_eret",    eret_commit, 1'b0);
        check("ovf_code",    exc_code,    5'd12);
        check("ovf_epc",     exc_epc,     32'hBFC0_0100);
        check("ovf_bd",      exc_bd,      1'b0);
        check("ovf_badv_we", badv_we,     1'b0);
        check("ovf_flush0",  flush_o,     1'b1);
        check("ovf_busy",    busy_o,      1'b1);
        check("ovf_rv0",     redirect_valid, 1'b0);
        // A lane fault presented during DRAIN must be ignored.
        valid_1 = 1'b1; exc_1 = 8'h01;
        #1;
        check("drain_kill_2", kill_2, 1'b0);
        tick();
        clear_inputs();
        check("ovf_commit_pulse", exc_commit, 1'b0);
        check("ovf_flush1",       flush_o,    1'b1);
        check("ovf_rv1",          redirect_valid, 1'b0);
        tick();
        check("ovf_flush2",   flush_o,        1'b0);
        check("ovf_rv2",      redirect_valid, 1'b1);
        check("ovf_redir_pc", redirect_pc,    32'hBFC0_0380);
        check("ovf_no_extra", exc_commit,     1'b0);
        tick();
        check("ovf_idle_lat", busy_o,   1'b0);
        check("ovf_hold_code", exc_code, 5'd12);

        // ---- Lane 2 syscall in a delay slot.
        valid_1 = 1'b1; branch_1 = 1'b1; pc_1 = 32'h8000_0010;
        valid_2 = 1'b1; pc_2 = 32'h8000_0014; exc_2 = 8'h10;
        #1;
        check("sys_kill_2", kill_2, 1'b0);
        tick();
        clear_inputs();
        check("sys_commit",  exc_commit, 1'b1);
        check("sys_code",    exc_code,   5'd8);
        check("sys_epc",     exc_epc,    32'h8000_0010);
        check("sys_bd",      exc_bd,     1'b1);
        check("sys_badv_we", badv_we,    1'b0);
        wait_idle("sys_idle");

        // ---- Both lanes fault: the lane 1 load-address fault wins.
        valid_1 = 1'b1; exc_1 = 8'h20; vaddr_1 = 32'h0000_1003; pc_1 = 32'h0000_0500;
        valid_2 = 1'b1; exc_2 = 8'h08; pc_2 = 32'h0000_0504;
        #1;
        check("both_kill_2", kill_2, 1'b1);
        tick();
        clear_inputs();
        commits = int'(exc_commit);
        check("both_code",    exc_code,     5'd4);
        check("both_badv_we", badv_we,      1'b1);
        check("both_badv",    exc_badvaddr, 32'h0000_1003);
        check("both_epc",     exc_epc,      32'h0000_0500);
        for (int i = 0; i < 3; i++) begin
            tick();
            commits += int'(exc_commit);
        end
        check("both_one_commit", commits, 1);
        check("both_idle",       busy_o,  1'b0);

        // ---- Interrupt beats a lane 2 fault. Lane 1 is in a delay slot.
        int_pending = 1'b1; status_exl = 1'b0;
        valid_1 = 1'b1; ds_1 = 1'b1; pc_1 = 32'h0000_0040;
        valid_2 = 1'b1; exc_2 = 8'h04; pc_2 = 32'h0000_0044;
        #1;
        check("int_kill_2", kill_2, 1'b1);
        tick();
        clear_inputs();
        check("int_commit",  exc_commit, 1'b1);
        check("int_code",    exc_code,   5'd0);
        check("int_epc",     exc_epc,    32'h0000_003C);
        check("int_bd",      exc_bd,     1'b1);
        check("int_badv_we", badv_we,    1'b0);
        wait_idle("int_idle");

        // ---- Lane 2 instruction-fetch address fault: BadVAddr is pc_2.
        valid_2 = 1'b1; exc_2 = 8'h01; pc_2 = 32'h0000_1234; vaddr_2 = 32'hDEAD_0000;
        tick();
        clear_inputs();
        check("if2_code",    exc_code,     5'd4);
        check("if2_epc",     exc_epc,      32'h0000_1234);
        check("if2_bd",      exc_bd,       1'b0);
        check("if2_badv_we", badv_we,      1'b1);
        check("if2_badv",    exc_badvaddr, 32'h0000_1234);
        wait_idle("if2_idle");

        // ---- EXL set: a lane fault is ignored.
        status_exl = 1'b1; valid_1 = 1'b1; exc_1 = 8'h04; pc_1 = 32'h0000_0800;
        #1;
        check("exl_kill_2", kill_2, 1'b0);
        tick();
        clear_inputs();
        check("exl_commit", exc_commit, 1'b0);
        check("exl_busy",   busy_o,     1'b0);

        // ---- ERET.
        valid_1 = 1'b1; exc_1 = 8'h40; status_exl = 1'b1; epc_i = 32'h8000_0200;
        #1;
        check("eret_kill_2", kill_2, 1'b1);
        tick();
        clear_inputs();
        check("eret_pulse",     eret_commit, 1'b1);
        check("eret_no_exc",    exc_commit,  1'b0);
        check("eret_hold_code", exc_code,    5'd4);
        check("eret_flush",     flush_o,     1'b1);
        tick();
        check("eret_pulse_end", eret_commit, 1'b0);
        tick();
        check("eret_rv",       redirect_valid, 1'b1);
        check("eret_redir_pc", redirect_pc,    32'h8000_0200);
        wait_idle("eret_idle");

        // ---- Redirect stall: lane 1 break with fetch not ready.
        redirect_ready = 1'b0;
        valid_1 = 1'b1; exc_1 = 8'h08; pc_1 = 32'h0000_0900;
        tick();
        clear_inputs();
        check("brk_code", exc_code, 5'd9);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_rv", redirect_valid, 1'b1);
            check("stall_pc", redirect_pc,    32'hBFC0_0380);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        check("stall_release", busy_o, 1'b0);

        // ---- Reset asserted during DRAIN.
        valid_1 = 1'b1; exc_1 = 8'h02; pc_1 = 32'h0000_0A00;
        tick();
        clear_inputs();
        check("ri_code",  exc_code, 5'd10);
        check("ri_flush", flush_o,  1'b1);
        valid_1 = 1'b1; exc_1 = 8'h04;
        #1 reset = 1'b0;
        #1;
        check("mid_rst_flush",  flush_o,      1'b0);
        check("mid_rst_busy",   busy_o,       1'b0);
        check("mid_rst_commit", exc_commit,   1'b0);
        check("mid_rst_code",   exc_code,     5'd0);
        check("mid_rst_epc",    exc_epc,      32'h0);
        check("mid_rst_bd",     exc_bd,       1'b0);
        check("mid_rst_rpc",    redirect_pc,  32'h0);
        check("mid_rst_kill_2", kill_2,       1'b0);
        clear_inputs();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_busy", busy_o, 1'b0);
        // The scheduler must accept a fresh event after reset.
        valid_1 = 1'b1; exc_1 = 8'h10; pc_1 = 32'h0000_0B00;
        tick();
        clear_inputs();
        check("post_rst_commit", exc_commit, 1'b1);
        check("post_rst_code",   exc_code,   5'd8);
        check("post_rst_flush",  flush_o,    1'b1);
        wait_idle("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
